data_memory_unit: RTL

//  Word-organised data memory answering load/store requests from the execution stage
//  (MemRead/MemWrite, ALU result as address, RData2 as store data). Responder side of the

---
 rtl/data_memory_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/data_memory_unit.sv
// Word-organised data memory for load/store requests from the execution stage.
// A request is accepted in IDLE, waits a fixed LATENCY in BUSY, and the
// response is held in RESP until the consumer takes it. Misaligned,
// out-of-range and malformed (both or neither of read/write) requests are
// answered with rsp_err and leave the memory untouched.
module data_memory_unit #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_en,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rdata,
   output logic        rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Depth widened to 31 bits so the 30-bit word index compares without truncation.
   localparam logic [30:0] DEPTH_W = 31'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  count_r;
   logic        op_read_r;
   logic        op_write_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  be_r;
   logic        req_ready_r;
   logic        rsp_valid_r;
   logic        rsp_err_r;
   logic [31:0] rdata_r;

   logic [31:0] mem_r [DEPTH];

   logic [29:0]      word_s;
   logic [IDX_W-1:0] idx_s;
   logic             err_s;
   logic             fire_s;
   logic             commit_s;
   logic [31:0]      load_word_s;

   // Decode the latched request: word index, legality, and the access-edge strobes.
   always_comb begin
      word_s      = addr_r[31:2];
      idx_s       = word_s[IDX_W-1:0];
      err_s       = (addr_r[1:0] != 2'b00)
                 || ({1'b0, word_s} >= DEPTH_W)
                 || (op_read_r == op_write_r);
      fire_s      = (state_r == ST_BUSY) && (count_r == 4'd0);
      commit_s    = rst_n && fire_s && op_write_r && !err_s;
      load_word_s = mem_r[idx_s];
   end

   // Request/response FSM with registered handshake and response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         count_r     <= 4'd0;
         op_read_r   <= 1'b0;
         op_write_r  <= 1'b0;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         be_r        <= 4'd0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rdata_r     <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready_r) begin
                  op_read_r   <= mem_read;
                  op_write_r  <= mem_write;
                  addr_r      <= addr;
                  wdata_r     <= wdata;
                  be_r        <= byte_en;
                  count_r     <= 4'(LATENCY - 1);
                  req_ready_r <= 1'b0;
                  state_r     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (count_r == 4'd0) begin
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= err_s;
                  rdata_r     <= (!err_s && op_read_r) ? load_word_s : 32'd0;
                  state_r     <= ST_RESP;
               end else begin
                  count_r <= count_r - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  rsp_err_r   <= 1'b0;
                  rdata_r     <= 32'd0;
                  req_ready_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               count_r     <= 4'd0;
               req_ready_r <= 1'b1;
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rdata_r     <= 32'd0;
            end
         endcase
      end
   end

   // Byte-lane store commit on the edge the response is produced; array is never reset.
   always_ff @(posedge clk) begin
      if (commit_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_r[i]) begin
               mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;
   assign rdata     = rdata_r;

endmodule
